imem_responder: RTL and testbench

Instruction-memory responder that serves the fetch stage's requests. It accepts a request (imem_req/imem_addr), reads a word-organised instruction store and returns imem_data with a valid strobe after a fixed, parameterised latency. Errors are flagged for misaligned or out-of-range addresses. A side write port loads the program before or during execution. It sits between the core's fetch unit and the instruction storage.

---
 rtl/imem_responder.sv | 131 +++++++++++++
 tb/tb_imem_responder.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/imem_responder.sv
// Instruction-memory responder for the fetch stage.
// Accepts a fetch request (imem_req/imem_addr) when imem_ready is high.
// It returns the addressed instruction word, or a NOP with imem_err set,
// with a one-cycle imem_valid pulse exactly LATENCY cycles later.
// A side program-load port writes the word store in any state.
//
// Ports:
//   clk, reset_n           clock (rising edge), async active-low reset
//   imem_req, imem_addr    fetch request strobe and byte address
//   imem_ready             request can be accepted this cycle (decoded from state)
//   imem_data, imem_valid  registered response word and its valid pulse
//   imem_err               registered access fault for the response
//   prog_we/addr/wdata     program-load write port (word index)
module imem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned LATENCY     = 1
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           imem_req,
  input  logic [31:0]                    imem_addr,
  output logic                           imem_ready,
  output logic [31:0]                    imem_data,
  output logic                           imem_valid,
  output logic                           imem_err,
  input  logic                           prog_we,
  input  logic [$clog2(DEPTH_WORDS)-1:0] prog_addr,
  input  logic [31:0]                    prog_wdata
);

  localparam int unsigned IDX_W    = $clog2(DEPTH_WORDS);
  localparam int unsigned CNT_W    = 4;
  localparam logic [31:0] NOP_WORD = 32'h0000_0013;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  logic [31:0]      mem [DEPTH_WORDS];
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      addr_q;
  logic             accept;
  logic             load;
  logic [31:0]      rd_addr;
  logic [31:0]      word_off;
  logic             fault;
  logic [IDX_W-1:0] rd_idx;

  assign imem_ready = (state_q != WAIT);
  assign accept     = imem_req && imem_ready;

  // Next-state and counter logic; load marks the edge entering RESP.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    case (state_q)
      IDLE, RESP: begin
        if (accept) begin
          if (LATENCY == 1) begin
            state_d = RESP;
            load    = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_INIT;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d = RESP;
          cnt_d   = '0;
          load    = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // With LATENCY=1 the load happens on the accept edge, so the live address is used.
  always_comb begin
    rd_addr  = (state_q == WAIT) ? addr_q : imem_addr;
    word_off = (rd_addr - BASE_ADDR) >> 2;
    fault    = (rd_addr[1:0] != 2'b00) || (rd_addr < BASE_ADDR) ||
               (word_off >= 32'(DEPTH_WORDS));
    rd_idx   = word_off[IDX_W-1:0];
  end

  // State, counter and captured request address.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) addr_q <= imem_addr;
    end
  end

  // Response registers; data/err hold between responses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      imem_valid <= 1'b0;
      imem_err   <= 1'b0;
      imem_data  <= '0;
    end else begin
      imem_valid <= load;
      if (load) begin
        imem_err  <= fault;
        imem_data <= fault ? NOP_WORD : mem[rd_idx];
      end
    end
  end

  // Word store, not reset; a same-edge write is not seen by the response load.
  always_ff @(posedge clk) begin
    if (prog_we) mem[prog_addr] <= prog_wdata;
  end

endmodule

// File: tb/tb_imem_responder.sv
module tb_imem_responder;

  logic clk;
  logic reset_n;

  // LATENCY=1 instance
  logic        req1, ready1, valid1, err1, we1;
  logic [31:0] addr1, data1, wd1;
  logic [9:0]  pa1;
  // LATENCY=3 instance
  logic        req3, ready3, valid3, err3, we3;
  logic [31:0] addr3, data3, wd3;
  logic [9:0]  pa3;

  int checks;
  int errors;

  imem_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .LATENCY(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .imem_req(req1), .imem_addr(addr1),
    .imem_ready(ready1), .imem_data(data1), .imem_valid(valid1), .imem_err(err1),
    .prog_we(we1), .prog_addr(pa1), .prog_wdata(wd1)
  );

  imem_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .LATENCY(3)) dut3 (
    .clk(clk), .reset_n(reset_n), .imem_req(req3), .imem_addr(addr3),
    .imem_ready(ready3), .imem_data(data3), .imem_valid(valid3), .imem_err(err3),
    .prog_we(we3), .prog_addr(pa3), .prog_wdata(wd3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    req1 = 0; addr1 = 0; we1 = 0; pa1 = 0; wd1 = 0;
    req3 = 0; addr3 = 0; we3 = 0; pa3 = 0; wd3 = 0;
    tick(); tick();
    checks++;
    if (valid1 !== 1'b0 || err1 !== 1'b0 || data1 !== 32'h0 || ready1 !== 1'b1) begin
      errors++;
      $display("FAIL reset_dut1: valid=%b err=%b data=%h ready=%b, want 0 0 00000000 1",
               valid1, err1, data1, ready1);
    end
    checks++;
    if (valid3 !== 1'b0 || err3 !== 1'b0 || data3 !== 32'h0 || ready3 !== 1'b1) begin
      errors++;
      $display("FAIL reset_dut3: valid=%b err=%b data=%h ready=%b, want 0 0 00000000 1",
               valid3, err3, data3, ready3);
    end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_single_lat3();
    we3 = 1; pa3 = 10'd4; wd3 = 32'h0050_0093;
    tick();
    we3 = 0;
    req3 = 1; addr3 = 32'h10;
    checks++;
    if (ready3 !== 1'b1) begin
      errors++; $display("FAIL lat3_ready_idle: got %b want 1", ready3);
    end
    tick();                         // accept edge
    req3 = 0;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (ready3 !== 1'b0 || valid3 !== 1'b0) begin
        errors++;
        $display("FAIL lat3_wait%0d: ready=%b valid=%b, want 0 0", i, ready3, valid3);
      end
      tick();
    end
    checks++;
    if (valid3 !== 1'b1 || data3 !== 32'h0050_0093 || err3 !== 1'b0 || ready3 !== 1'b1) begin
      errors++;
      $display("FAIL lat3_resp: valid=%b data=%h err=%b ready=%b, want 1 00500093 0 1",
               valid3, data3, err3, ready3);
    end
    tick();
    checks++;
    if (valid3 !== 1'b0 || data3 !== 32'h0050_0093) begin
      errors++;
      $display("FAIL lat3_hold: valid=%b data=%h, want 0 00500093", valid3, data3);
    end
  endtask

  task automatic test_ignored_req();
    req3 = 1; addr3 = 32'h10;
    tick();                         // accepted
    addr3 = 32'h6;                  // held request while not ready must be dropped
    tick(); tick();
    req3 = 0;
    checks++;
    if (valid3 !== 1'b1 || err3 !== 1'b0 || data3 !== 32'h0050_0093) begin
      errors++;
      $display("FAIL ignored_resp: valid=%b err=%b data=%h, want 1 0 00500093",
               valid3, err3, data3);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (valid3 !== 1'b0) begin
        errors++; $display("FAIL ignored_no_extra%0d: valid=%b want 0", i, valid3);
      end
    end
  endtask

  task automatic test_reset_mid();
    req3 = 1; addr3 = 32'h10;
    tick();                         // accepted, now in WAIT
    req3 = 0;
    reset_n = 1'b0;
    #1;
    checks++;
    if (valid3 !== 1'b0 || err3 !== 1'b0 || data3 !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid: valid=%b err=%b data=%h, want 0 0 00000000",
               valid3, err3, data3);
    end
    tick(); tick();
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (valid3 !== 1'b0 || ready3 !== 1'b1) begin
        errors++;
        $display("FAIL reset_release%0d: valid=%b ready=%b, want 0 1", i, valid3, ready3);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp [3];
    exp[0] = 32'hAAAA_0001; exp[1] = 32'hBBBB_0002; exp[2] = 32'hCCCC_0003;
    for (int i = 0; i < 3; i++) begin
      we1 = 1; pa1 = 10'(i); wd1 = exp[i];
      tick();
    end
    we1 = 0;
    req1 = 1; addr1 = 32'h0;
    for (int i = 0; i < 3; i++) begin
      tick();
      addr1 = 32'(4 * (i + 1));
      if (i == 2) req1 = 0;
      checks++;
      if (valid1 !== 1'b1 || data1 !== exp[i] || err1 !== 1'b0 || ready1 !== 1'b1) begin
        errors++;
        $display("FAIL b2b_%0d: valid=%b data=%h err=%b ready=%b, want 1 %h 0 1",
                 i, valid1, data1, err1, ready1, exp[i]);
      end
    end
    tick();
    checks++;
    if (valid1 !== 1'b0) begin
      errors++; $display("FAIL b2b_end: valid=%b want 0", valid1);
    end
  endtask

  task automatic test_errors();
    logic [31:0] addrs [4];
    logic        exp_err [4];
    logic [31:0] exp_data [4];
    we1 = 1; pa1 = 10'd1023; wd1 = 32'hCAFE_F00D;
    tick();
    we1 = 0;
    addrs[0] = 32'h0000_0006; exp_err[0] = 1; exp_data[0] = 32'h0000_0013;
    addrs[1] = 32'h0000_1000; exp_err[1] = 1; exp_data[1] = 32'h0000_0013;
    addrs[2] = 32'h0000_0FFC; exp_err[2] = 0; exp_data[2] = 32'hCAFE_F00D;
    addrs[3] = 32'hFFFF_FFFC; exp_err[3] = 1; exp_data[3] = 32'h0000_0013;
    for (int i = 0; i < 4; i++) begin
      req1 = 1; addr1 = addrs[i];
      tick();
      req1 = 0;
      checks++;
      if (valid1 !== 1'b1 || err1 !== exp_err[i] || data1 !== exp_data[i]) begin
        errors++;
        $display("FAIL addr_chk_%h: valid=%b err=%b data=%h, want 1 %b %h",
                 addrs[i], valid1, err1, data1, exp_err[i], exp_data[i]);
      end
      tick();
    end
  endtask

  task automatic test_collision();
    we1 = 1; pa1 = 10'd2; wd1 = 32'h1111_1111;
    tick();
    req1 = 1; addr1 = 32'h8;
    we1 = 1; pa1 = 10'd2; wd1 = 32'h2222_2222;
    tick();
    req1 = 0; we1 = 0;
    checks++;
    if (valid1 !== 1'b1 || data1 !== 32'h1111_1111) begin
      errors++;
      $display("FAIL collision_old: valid=%b data=%h, want 1 11111111", valid1, data1);
    end
    tick();
    req1 = 1; addr1 = 32'h8;
    tick();
    req1 = 0;
    checks++;
    if (valid1 !== 1'b1 || data1 !== 32'h2222_2222 || err1 !== 1'b0) begin
      errors++;
      $display("FAIL collision_new: valid=%b data=%h err=%b, want 1 22222222 0",
               valid1, data1, err1);
    end
    tick();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single_lat3();
    test_ignored_req();
    test_reset_mid();
    test_back_to_back();
    test_errors();
    test_collision();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
